// File: rtl/dht11_pkg.sv
// dht11_pkg: frame geometry, FSM state and error encodings shared by the DHT11 frame assembler
package dht11_pkg;
  localparam int FRAME_BITS = 40;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_CSUM = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_OVERRUN = 2'b11;
  localparam int BYTE_HUM_INT = 0;
  localparam int BYTE_HUM_DEC = 1;
  localparam int BYTE_TEMP_INT = 2;
  localparam int BYTE_TEMP_DEC = 3;
  localparam int BYTE_CSUM = 4;
  function automatic logic [7:0] frame_byte(input logic [FRAME_BITS-1:0] f, input int i);
    return f[FRAME_BITS-1-8*i -: 8];
  endfunction
endpackage

// File: rtl/dht11_timeout_timer.sv
// dht11_timeout_timer: clear/enable counter flagging its terminal count TIMEOUT_CYC-1
module dht11_timeout_timer #(
  parameter int TIMEOUT_CYC = 2000,
  parameter int CNT_W = 11
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic term
);
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= (rst || clr) ? '0 : en ? cnt + 1'b1 : cnt;
  assign term = cnt == CNT_W'(TIMEOUT_CYC - 1);
endmodule

// File: rtl/dht11_frame_assembler.sv
// dht11_frame_assembler: 40-bit DHT11 frame collect + checksum; DHT11_ERRCNT_EN adds err_count
module dht11_frame_assembler
  import dht11_pkg::*;
#(
  parameter int TIMEOUT_CYC = 2000,
  parameter int CNT_W = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       bit_valid,
  input  logic       bit_data,
  output logic [7:0] hum_int,
  output logic [7:0] hum_dec,
  output logic [7:0] temp_int,
  output logic [7:0] temp_dec,
  output logic       frame_valid,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
`ifdef DHT11_ERRCNT_EN
  ,output logic [7:0] err_count
`endif
);
  logic [1:0] state;
  logic [FRAME_BITS-1:0] sr;
  logic [5:0] bit_cnt;
  logic [7:0] csum;
  logic tmo;
  assign busy = state != ST_IDLE;
  assign csum = frame_byte(sr, BYTE_HUM_INT) + frame_byte(sr, BYTE_HUM_DEC)
              + frame_byte(sr, BYTE_TEMP_INT) + frame_byte(sr, BYTE_TEMP_DEC);
  dht11_timeout_timer #(.TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(CNT_W)) u_timer (
    .clk(clk),
    .rst(rst),
    .clr(state != ST_COLLECT || bit_valid || start),
    .en(state == ST_COLLECT),
    .term(tmo)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      sr <= '0;
      bit_cnt <= '0;
      hum_int <= '0;
      hum_dec <= '0;
      temp_int <= '0;
      temp_dec <= '0;
      frame_valid <= 1'b0;
      frame_err <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      frame_valid <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          sr <= '0;
          bit_cnt <= '0;
          err_code <= ERR_NONE;
          state <= ST_COLLECT;
        end
        ST_COLLECT: if (start) begin
          sr <= '0;
          bit_cnt <= '0;
        end else if (bit_valid) begin
          sr <= {sr[FRAME_BITS-2:0], bit_data};
          bit_cnt <= bit_cnt + 6'd1;
          state <= bit_cnt == 6'(FRAME_BITS - 1) ? ST_CHECK : ST_COLLECT;
        end else if (tmo) begin
          frame_err <= 1'b1;
          err_code <= ERR_TIMEOUT;
          state <= ST_IDLE;
        end
        ST_CHECK: begin
          state <= ST_IDLE;
          if (bit_valid) begin
            frame_err <= 1'b1;
            err_code <= ERR_OVERRUN;
          end else if (csum == frame_byte(sr, BYTE_CSUM)) begin
            hum_int <= frame_byte(sr, BYTE_HUM_INT);
            hum_dec <= frame_byte(sr, BYTE_HUM_DEC);
            temp_int <= frame_byte(sr, BYTE_TEMP_INT);
            temp_dec <= frame_byte(sr, BYTE_TEMP_DEC);
            frame_valid <= 1'b1;
            err_code <= ERR_NONE;
          end else begin
            frame_err <= 1'b1;
            err_code <= ERR_CSUM;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
`ifdef DHT11_ERRCNT_EN
  always_ff @(posedge clk)
    err_count <= rst ? 8'd0 : err_count + 8'(frame_err && err_count != 8'hff);
`endif
endmodule

// File: tb/tb_dht11_frame_assembler.sv
// tb_dht11_frame_assembler: randomized frames vs. byte-level checksum model, queue scoreboard
module tb_dht11_frame_assembler;
  localparam int TMO = 2000;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, bit_valid = 1'b0, bit_data = 1'b0;
  logic [7:0] hum_int, hum_dec, temp_int, temp_dec;
  logic frame_valid, frame_err, busy;
  logic [1:0] err_code;
`ifdef DHT11_ERRCNT_EN
  logic [7:0] err_count;
`endif
  dht11_frame_assembler #(.TIMEOUT_CYC(TMO), .CNT_W(11)) dut (
    .clk(clk), .rst(rst), .start(start), .bit_valid(bit_valid), .bit_data(bit_data),
    .hum_int(hum_int), .hum_dec(hum_dec), .temp_int(temp_int), .temp_dec(temp_dec),
    .frame_valid(frame_valid), .frame_err(frame_err), .err_code(err_code), .busy(busy)
`ifdef DHT11_ERRCNT_EN
    , .err_count(err_count)
`endif
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int tests = 0, fails = 0;
  typedef struct {
    bit is_err;
    logic [1:0] code;
    logic [31:0] data;
    int at;
  } ev_t;
  ev_t q[$];
  logic [31:0] good = '0;
  int exp_errs = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [39:0] mk(input logic [31:0] d, input bit bad);
    int s = d[31:24] + d[23:16] + d[15:8] + d[7:0];
    logic [7:0] c = 8'(s % 256);
    return {d, bad ? c ^ 8'(1 + $urandom_range(0, 254)) : c};
  endfunction

  task automatic expect_ev(input bit is_err, input logic [1:0] code, input int dt);
    ev_t e;
    e.is_err = is_err;
    e.code = code;
    e.data = good;
    e.at = cyc + dt;
    q.push_back(e);
    if (is_err) exp_errs++;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_bit(input logic b, input int gap);
    repeat (gap) @(negedge clk);
    bit_data = b;
    bit_valid = 1'b1;
    @(negedge clk);
    bit_valid = 1'b0;
  endtask

  task automatic finish_frame(input logic [39:0] f, input bit ovr);
    int s = f[39:32] + f[31:24] + f[23:16] + f[15:8];
    if (ovr) expect_ev(1, 2'b11, 1);
    else if (s % 256 == int'(f[7:0])) begin
      good = f[39:8];
      expect_ev(0, 2'b00, 1);
    end else expect_ev(1, 2'b01, 1);
    if (ovr) begin
      bit_valid = 1'b1;
      @(negedge clk);
      bit_valid = 1'b0;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic send_frame(input logic [39:0] f, input int gap, input bit ovr);
    pulse_start();
    for (int i = 0; i < 40; i++) send_bit(f[39-i], gap);
    finish_frame(f, ovr);
  endtask

  always @(negedge clk) begin
    if (!rst && (frame_valid || frame_err)) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_event: valid=%0b err=%0b code=%0d cycle=%0d", frame_valid, frame_err, err_code, cyc);
      end else begin
        ev_t e;
        e = q.pop_front();
        chk("event_kind", 32'({frame_err, frame_valid}), e.is_err ? 32'd2 : 32'd1);
        chk("event_cycle", cyc, e.at);
        chk("err_code", 32'(err_code), 32'(e.code));
        chk("data_out", {hum_int, hum_dec, temp_int, temp_dec}, e.data);
        chk("busy_after_event", 32'(busy), 32'd0);
      end
    end
  end

  initial begin
    logic [39:0] f;
    repeat (3) @(negedge clk);
    chk("rst_data", {hum_int, hum_dec, temp_int, temp_dec}, 32'd0);
    chk("rst_flags", 32'({frame_valid, frame_err, err_code, busy}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    // T1 good frame, slow bit rate
    send_frame(40'h37_00_19_05_55, 499, 0);
    chk("t1_data", {hum_int, hum_dec, temp_int, temp_dec}, 32'h37001905);
    // T2 bad checksum keeps T1 data; err_code holds while idle
    send_frame(40'h37_00_19_05_54, 3, 0);
    repeat (20) @(negedge clk);
    chk("t2_err_hold", 32'(err_code), 32'd1);
    // T3 timeout after 12 bits
    pulse_start();
    chk("t3_start_clears_err", 32'(err_code), 32'd0);
    chk("t3_busy", 32'(busy), 32'd1);
    f = mk($urandom, 0);
    for (int i = 0; i < 12; i++) send_bit(f[39-i], $urandom_range(0, 10));
    expect_ev(1, 2'b10, TMO);
    repeat (TMO + 10) @(negedge clk);
    chk("t3_busy_idle", 32'(busy), 32'd0);
    chk("t3_err_code", 32'(err_code), 32'd2);
    // T4 bit on the terminal timer cycle wins
    pulse_start();
    f = mk($urandom, 0);
    for (int i = 0; i < 40; i++) send_bit(f[39-i], i == 5 ? TMO - 1 : i == 6 ? TMO - 2 : 2);
    finish_frame(f, 0);
    // T5 restart after 20 bits
    pulse_start();
    f = mk($urandom, 0);
    for (int i = 0; i < 20; i++) send_bit(f[39-i], 1);
    send_frame(mk($urandom, 0), $urandom_range(0, 5), 0);
    // T5 reset mid-frame
    pulse_start();
    for (int i = 0; i < 15; i++) send_bit(f[39-i], 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    good = '0;
    exp_errs = 0;
    @(negedge clk);
    chk("t5_rst_data", {hum_int, hum_dec, temp_int, temp_dec}, 32'd0);
    chk("t5_rst_flags", 32'({frame_valid, frame_err, err_code, busy}), 32'd0);
    repeat (10) @(negedge clk);
    // T6 overrun beats a correct checksum
    send_frame(mk($urandom, 0), 1, 1);
    chk("t6_err_code", 32'(err_code), 32'd3);
`ifdef DHT11_ERRCNT_EN
    chk("t6_err_count", 32'(err_count), 32'd1);
`endif
    for (int n = 0; n < 20; n++) send_frame(mk($urandom, $urandom_range(0, 1) == 1), $urandom_range(0, 20), 0);
`ifdef DHT11_ERRCNT_EN
    for (int n = 0; n < 300; n++) send_frame(mk($urandom, 1), 0, 0);
    chk("err_count_sat", 32'(err_count), exp_errs > 255 ? 32'd255 : 32'(exp_errs));
`endif
    repeat (10) @(negedge clk);
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
